lcd_panel_probe: RTL and testbench

Power-up sequencer for the RGB LCD path. After reset it tri-states the RGB bus and samples the panel strap pins M2/M1/M0 with a consistency check, then decodes them into the 16-bit `lcd_id` consumed by the pixel-clock divider and the timing generator. It then releases the pixel clock, re-enables the RGB bus and turns on the backlight, each after a programmable delay. It sits between the board pads and the clock-divider/LCD-driver blocks, and is re-triggerable by a `reprobe` pulse.

---
 rtl/lcd_panel_probe.sv | 221 ++++++++++++++++++++++
 tb/tb_lcd_panel_probe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_panel_probe.sv
// Purpose : power-up sequencer for the RGB LCD path. Tri-states the bus, samples
//           the M2/M1/M0 straps until NUM_SAMPLES agree, decodes lcd_id, then
//           releases pclk_en/rgb_oe and, later, lcd_bl. Re-run with reprobe.
// Latency : reset to lcd_bl = SETTLE_CYC+(NUM_SAMPLES-1)*SAMPLE_GAP+2+CLK_SETTLE+BL_DELAY cycles.
// Backpr. : none; reprobe is a single-cycle request honoured only in RUN or FAULT.
// Ports   : clk, rst_n (async, active-low), reprobe, lcd_rgb_in[23:0] (straps on
//           bits 23/15/7 = M0/M1/M2); outputs rgb_oe, lcd_id[15:0], id_valid,
//           id_err, pclk_en, lcd_bl, busy (all registered).
module lcd_panel_probe #(
  parameter int SETTLE_CYC  = 1000,
  parameter int SAMPLE_GAP  = 16,
  parameter int NUM_SAMPLES = 4,
  parameter int MAX_RETRY   = 3,
  parameter int CLK_SETTLE  = 16,
  parameter int BL_DELAY    = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reprobe,
  input  logic [23:0] lcd_rgb_in,
  output logic        rgb_oe,
  output logic [15:0] lcd_id,
  output logic        id_valid,
  output logic        id_err,
  output logic        pclk_en,
  output logic        lcd_bl,
  output logic        busy
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max_of(max_of(SETTLE_CYC, SAMPLE_GAP), max_of(CLK_SETTLE, BL_DELAY));
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NUM_SAMPLES);
  localparam int RW      = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_SETTLE, S_SAMPLE, S_DECIDE, S_CLK_WAIT, S_BL_WAIT, S_RUN, S_FAULT
  } state_t;

  // {known, id}
  function automatic logic [16:0] decode(input logic [2:0] m);
    case (m)
      3'b000:  return {1'b1, 16'h4342};
      3'b001:  return {1'b1, 16'h7084};
      3'b010:  return {1'b1, 16'h7016};
      3'b100:  return {1'b1, 16'h4384};
      3'b101:  return {1'b1, 16'h1018};
      default: return {1'b0, 16'h0000};
    endcase
  endfunction

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [IW-1:0]   idx, idx_d;
  logic [RW-1:0]   retry, retry_d;
  logic [2:0]      ref_strap, ref_strap_d;
  logic [2:0]      strap_s1, strap_s2;
  logic [16:0]     dec;
  logic            rgb_oe_d, id_valid_d, id_err_d, pclk_en_d, lcd_bl_d, busy_d;
  logic [15:0]     lcd_id_d;

  // Only the three strap bits are observed; the rest of the pad bus is ignored.
  logic unused_rgb;
  assign unused_rgb = ^{lcd_rgb_in[22:16], lcd_rgb_in[14:8], lcd_rgb_in[6:0]};

  // Straps ordered {M2, M1, M0}, double-flopped before any sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strap_s1 <= 3'b000;
      strap_s2 <= 3'b000;
    end else begin
      strap_s1 <= {lcd_rgb_in[7], lcd_rgb_in[15], lcd_rgb_in[23]};
      strap_s2 <= strap_s1;
    end
  end

  assign dec = decode(ref_strap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_SETTLE;
      cnt       <= CW'(SETTLE_CYC - 1);
      idx       <= '0;
      retry     <= '0;
      ref_strap <= 3'b000;
      rgb_oe    <= 1'b0;
      lcd_id    <= 16'h0000;
      id_valid  <= 1'b0;
      id_err    <= 1'b0;
      pclk_en   <= 1'b0;
      lcd_bl    <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      retry     <= retry_d;
      ref_strap <= ref_strap_d;
      rgb_oe    <= rgb_oe_d;
      lcd_id    <= lcd_id_d;
      id_valid  <= id_valid_d;
      id_err    <= id_err_d;
      pclk_en   <= pclk_en_d;
      lcd_bl    <= lcd_bl_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    idx_d       = idx;
    retry_d     = retry;
    ref_strap_d = ref_strap;
    rgb_oe_d    = rgb_oe;
    lcd_id_d    = lcd_id;
    id_valid_d  = id_valid;
    id_err_d    = id_err;
    pclk_en_d   = pclk_en;
    lcd_bl_d    = lcd_bl;
    busy_d      = busy;

    case (state)
      S_SETTLE: begin
        if (cnt == '0) begin
          state_d = S_SAMPLE;
          idx_d   = '0;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end

      // The counter is zero on each sampling cycle; idx 0 captures the reference.
      S_SAMPLE: begin
        if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
        end else if (idx == '0) begin
          ref_strap_d = strap_s2;
          idx_d       = IW'(1);
          cnt_d       = CW'(SAMPLE_GAP - 1);
        end else if (strap_s2 != ref_strap) begin
          if (retry == RW'(MAX_RETRY - 1)) begin
            state_d = S_FAULT;
          end else begin
            retry_d = retry + RW'(1);
            idx_d   = '0;
            cnt_d   = CW'(SAMPLE_GAP - 1);
          end
        end else if (idx == IW'(NUM_SAMPLES - 1)) begin
          state_d = S_DECIDE;
        end else begin
          idx_d = idx + IW'(1);
          cnt_d = CW'(SAMPLE_GAP - 1);
        end
      end

      S_DECIDE: begin
        if (dec[16]) begin
          lcd_id_d   = dec[15:0];
          id_valid_d = 1'b1;
          state_d    = S_CLK_WAIT;
          cnt_d      = CW'(CLK_SETTLE - 1);
        end else begin
          state_d = S_FAULT;
        end
      end

      S_CLK_WAIT: begin
        if (cnt == '0) begin
          pclk_en_d = 1'b1;
          rgb_oe_d  = 1'b1;
          state_d   = S_BL_WAIT;
          cnt_d     = CW'(BL_DELAY - 1);
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end

      S_BL_WAIT: begin
        if (cnt == '0) begin
          lcd_bl_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_RUN;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end

      default: ;  // S_RUN, S_FAULT hold until reprobe
    endcase

    // Entering FAULT forces the safe output set in the same edge.
    if (state != S_FAULT && state_d == S_FAULT) begin
      lcd_id_d   = 16'h0000;
      id_valid_d = 1'b0;
      id_err_d   = 1'b1;
      rgb_oe_d   = 1'b0;
      pclk_en_d  = 1'b0;
      lcd_bl_d   = 1'b0;
      busy_d     = 1'b0;
    end

    // lcd_id is deliberately left alone so downstream keeps the last ID until re-decided.
    if ((state == S_RUN || state == S_FAULT) && reprobe) begin
      state_d    = S_SETTLE;
      cnt_d      = CW'(SETTLE_CYC - 1);
      idx_d      = '0;
      retry_d    = '0;
      rgb_oe_d   = 1'b0;
      id_valid_d = 1'b0;
      id_err_d   = 1'b0;
      pclk_en_d  = 1'b0;
      lcd_bl_d   = 1'b0;
      busy_d     = 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_panel_probe.sv
// Purpose : self-checking bench for lcd_panel_probe with small timing parameters.
// Latency : expected edge indices derived from the parameters below.
// Backpr. : n/a.
module tb_lcd_panel_probe;

  localparam int P_SETTLE = 8;
  localparam int P_GAP    = 4;
  localparam int P_NUM    = 4;
  localparam int P_RETRY  = 3;
  localparam int P_CLK    = 16;
  localparam int P_BL     = 32;

  // Edge index (cycle 0 = first rising edge after release) of each event.
  localparam int T_IDV  = P_SETTLE + (P_NUM - 1) * P_GAP + 1;  // 21
  localparam int T_PCLK = T_IDV + P_CLK;                        // 37
  localparam int T_BL   = T_PCLK + P_BL;                        // 69
  localparam int T_RST  = P_NUM - 1;                            // restart shift in samples

  logic        clk;
  logic        rst_n;
  logic        reprobe;
  logic [23:0] lcd_rgb_in;
  logic        rgb_oe;
  logic [15:0] lcd_id;
  logic        id_valid;
  logic        id_err;
  logic        pclk_en;
  logic        lcd_bl;
  logic        busy;

  lcd_panel_probe #(
    .SETTLE_CYC (P_SETTLE),
    .SAMPLE_GAP (P_GAP),
    .NUM_SAMPLES(P_NUM),
    .MAX_RETRY  (P_RETRY),
    .CLK_SETTLE (P_CLK),
    .BL_DELAY   (P_BL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reprobe   (reprobe),
    .lcd_rgb_in(lcd_rgb_in),
    .rgb_oe    (rgb_oe),
    .lcd_id    (lcd_id),
    .id_valid  (id_valid),
    .id_err    (id_err),
    .pclk_en   (pclk_en),
    .lcd_bl    (lcd_bl),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= -1;
    else        edge_n <= edge_n + 1;
  end

  typedef struct {
    logic [15:0] id;
    logic        err;
    logic        oe;
    int          t_idv;
    int          t_pclk;
    int          t_bl;
    int          t_done;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic logic [23:0] pins(input logic [2:0] m);
    logic [23:0] r;
    r     = 24'h3C5A69;
    r[7]  = m[2];
    r[15] = m[1];
    r[23] = m[0];
    return r;
  endfunction

  function automatic exp_t mk(input logic [15:0] id, input logic err, input logic oe,
                              input int ti, input int tp, input int tb, input int td);
    exp_t e;
    e.id = id; e.err = err; e.oe = oe;
    e.t_idv = ti; e.t_pclk = tp; e.t_bl = tb; e.t_done = td;
    return e;
  endfunction

  task automatic chk_reset(input string p);
    check({p, "_oe"},   rgb_oe,   0);
    check({p, "_id"},   lcd_id,   16'h0000);
    check({p, "_idv"},  id_valid, 0);
    check({p, "_err"},  id_err,   0);
    check({p, "_pclk"}, pclk_en,  0);
    check({p, "_bl"},   lcd_bl,   0);
    check({p, "_busy"}, busy,     1);
  endtask

  // Pulses reprobe for one edge; base is the edge index that counts as cycle 0.
  task automatic do_reprobe(input string p, input logic [2:0] m, output int base);
    logic [15:0] id_before;
    @(negedge clk);
    id_before  = lcd_id;
    lcd_rgb_in = pins(m);
    reprobe    = 1'b1;
    @(negedge clk);
    reprobe = 1'b0;
    base    = edge_n + 1;
    check({p, "_rp_bl"},   lcd_bl,   0);
    check({p, "_rp_pclk"}, pclk_en,  0);
    check({p, "_rp_oe"},   rgb_oe,   0);
    check({p, "_rp_idv"},  id_valid, 0);
    check({p, "_rp_err"},  id_err,   0);
    check({p, "_rp_busy"}, busy,     1);
    check({p, "_rp_hold"}, lcd_id,   id_before);
  endtask

  // mode 0: static straps, 1: one glitch between samples 1 and 2,
  // 2: toggle M0 every SAMPLE_GAP, 3: reprobe pulse during SAMPLE.
  // stop_rel >= 0 returns early at that cycle without scoring.
  task automatic run_seq(input string p, input int base, input int mode, input int stop_rel);
    int   t_idv, t_pclk, t_bl, t_done, rel;
    bit   p_idv, p_pclk, p_bl, ord_bad, done, stopped;
    exp_t e;
    t_idv = -1; t_pclk = -1; t_bl = -1; t_done = -1;
    p_idv = id_valid; p_pclk = pclk_en; p_bl = lcd_bl;
    ord_bad = 0; done = 0; stopped = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      rel = edge_n - base;
      if (id_valid && !p_idv && t_idv < 0) t_idv = rel;
      if (pclk_en && !p_pclk && t_pclk < 0) t_pclk = rel;
      if (lcd_bl && !p_bl && t_bl < 0) t_bl = rel;
      if (pclk_en && !id_valid) ord_bad = 1;
      if (lcd_bl && !pclk_en) ord_bad = 1;
      p_idv = id_valid; p_pclk = pclk_en; p_bl = lcd_bl;
      case (mode)
        1: begin
          if (rel == 12) lcd_rgb_in = pins(3'b000);
          if (rel == 16) lcd_rgb_in = pins(3'b001);
        end
        2: if (rel >= 0 && rel % P_GAP == 0) lcd_rgb_in[23] = ~lcd_rgb_in[23];
        3: begin
          if (rel == 9)  reprobe = 1'b1;
          if (rel == 10) reprobe = 1'b0;
        end
        default: ;
      endcase
      if (stop_rel >= 0 && rel == stop_rel) begin
        done = 1; stopped = 1;
      end else if (!busy) begin
        t_done = rel; done = 1;
      end
    end
    check({p, "_timeout"}, done, 1);
    if (!stopped) begin
      check({p, "_order"}, ord_bad, 0);
      check({p, "_sb_avail"}, (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({p, "_id"},     lcd_id,   e.id);
        check({p, "_idv"},    id_valid, !e.err);
        check({p, "_err"},    id_err,   e.err);
        check({p, "_oe"},     rgb_oe,   e.oe);
        check({p, "_t_idv"},  t_idv,    e.t_idv);
        check({p, "_t_pclk"}, t_pclk,   e.t_pclk);
        check({p, "_t_bl"},   t_bl,     e.t_bl);
        check({p, "_t_done"}, t_done,   e.t_done);
      end
    end
  endtask

  int base;

  initial begin
    rst_n      = 1'b0;
    reprobe    = 1'b0;
    lcd_rgb_in = pins(3'b010);
    #23;
    chk_reset("rst");

    // Straps 010 from reset.
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk(16'h7016, 0, 1, T_IDV, T_PCLK, T_BL, T_BL));
    run_seq("s010", 0, 0, -1);

    // 000 then 101 via reprobe; lcd_id holds until the next decide.
    do_reprobe("s000", 3'b000, base);
    sb.push_back(mk(16'h4342, 0, 1, T_IDV, T_PCLK, T_BL, T_BL));
    run_seq("s000", base, 0, -1);
    do_reprobe("s101", 3'b101, base);
    sb.push_back(mk(16'h1018, 0, 1, T_IDV, T_PCLK, T_BL, T_BL));
    run_seq("s101", base, 0, -1);

    // Unknown code: FAULT straight out of DECIDE.
    do_reprobe("s111", 3'b111, base);
    sb.push_back(mk(16'h0000, 1, 0, -1, -1, -1, T_IDV));
    run_seq("s111", base, 0, -1);

    // One glitch: a single retry shifts everything by the restart.
    do_reprobe("glitch", 3'b001, base);
    sb.push_back(mk(16'h7084, 0, 1, T_IDV + T_RST * P_GAP, T_PCLK + T_RST * P_GAP,
                    T_BL + T_RST * P_GAP, T_BL + T_RST * P_GAP));
    run_seq("glitch", base, 1, -1);

    // Toggling straps: every sample 1 mismatches until the retry budget runs out.
    do_reprobe("toggle", 3'b001, base);
    sb.push_back(mk(16'h0000, 1, 0, -1, -1, -1, P_SETTLE + (2 * P_RETRY - 1) * P_GAP));
    run_seq("toggle", base, 2, -1);

    // Async reset in BL_WAIT, then a full rerun with an ignored reprobe in SAMPLE.
    @(negedge clk);
    lcd_rgb_in = pins(3'b100);
    rst_n      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_seq("blw", 0, 0, T_PCLK + 13);
    check("blw_pclk", pclk_en, 1);
    check("blw_bl",   lcd_bl,  0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("arst");
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk(16'h4384, 0, 1, T_IDV, T_PCLK, T_BL, T_BL));
    run_seq("rerun", 0, 3, -1);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
